// File: rtl/apb_periph_node.sv
// ---------------------------------------------------------------------------
// apb_periph_node
//   APB 1-to-N peripheral interconnect node. One upstream APB transfer is
//   decoded against runtime start/end address windows and forwarded to one
//   of NB_MASTER downstream peripheral ports. Decode is registered, a decode
//   miss returns an error response, and a per-transfer timeout forces an
//   error when a slave never completes.
//
//   Optional build macro: APB_NODE_ERR_LOG_EN adds a sticky error log
//   (err_clr_i, err_valid_o, err_addr_o, err_cause_o).
//
// Ports
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   psel_i .. pwdata_i  upstream APB request
//   prdata_o, pready_o, pslverr_o   upstream APB response (valid in RESP)
//   start_addr_i / end_addr_i       per-port inclusive address windows
//   m_psel_o            downstream one-hot select
//   m_penable_o, m_paddr_o, m_pwrite_o, m_pwdata_o  downstream broadcast
//   m_prdata_i, m_pready_i, m_pslverr_i             downstream responses
//   err_*               error log (APB_NODE_ERR_LOG_EN only)
// ---------------------------------------------------------------------------
module apb_periph_node #(
   parameter int unsigned NB_MASTER      = 10,
   parameter int unsigned APB_ADDR_WIDTH = 32,
   parameter int unsigned APB_DATA_WIDTH = 32,
   parameter int unsigned TIMEOUT_CYCLES = 256,
   parameter logic [31:0] ERR_RDATA      = 32'hBADACCE5
) (
   input  logic                                  clk_i,
   input  logic                                  rst_ni,
   input  logic                                  psel_i,
   input  logic                                  penable_i,
   input  logic [APB_ADDR_WIDTH-1:0]             paddr_i,
   input  logic                                  pwrite_i,
   input  logic [APB_DATA_WIDTH-1:0]             pwdata_i,
   output logic [APB_DATA_WIDTH-1:0]             prdata_o,
   output logic                                  pready_o,
   output logic                                  pslverr_o,
   input  logic [NB_MASTER*APB_ADDR_WIDTH-1:0]   start_addr_i,
   input  logic [NB_MASTER*APB_ADDR_WIDTH-1:0]   end_addr_i,
   output logic [NB_MASTER-1:0]                  m_psel_o,
   output logic                                  m_penable_o,
   output logic [APB_ADDR_WIDTH-1:0]             m_paddr_o,
   output logic                                  m_pwrite_o,
   output logic [APB_DATA_WIDTH-1:0]             m_pwdata_o,
   input  logic [NB_MASTER*APB_DATA_WIDTH-1:0]   m_prdata_i,
   input  logic [NB_MASTER-1:0]                  m_pready_i,
   input  logic [NB_MASTER-1:0]                  m_pslverr_i
`ifdef APB_NODE_ERR_LOG_EN
   ,
   input  logic                                  err_clr_i,
   output logic                                  err_valid_o,
   output logic [APB_ADDR_WIDTH-1:0]             err_addr_o,
   output logic [1:0]                            err_cause_o
`endif
);

   localparam int unsigned IDX_W = (NB_MASTER > 1) ? $clog2(NB_MASTER) : 1;
   localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST =
      CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
   localparam logic [APB_DATA_WIDTH-1:0] ERR_DATA = APB_DATA_WIDTH'(ERR_RDATA);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_ACCESS,
      ST_ERR,
      ST_RESP
   } state_t;

   state_t             state_q;
   logic [IDX_W-1:0]   idx_q;
   logic               miss_q;
   logic [CNT_W-1:0]   cnt_q;

   logic               hit;
   logic [IDX_W-1:0]   hit_idx;
   logic               sel_ready;
   logic               sel_err;
   logic [APB_DATA_WIDTH-1:0] sel_rdata;
   logic               timeout_hit;

`ifdef APB_NODE_ERR_LOG_EN
   logic [1:0]         resp_cause_q;
`endif

   // Address decode on the live upstream address; lowest index wins on overlap.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int unsigned i = 0; i < NB_MASTER; i++) begin
         if (!hit &&
             (paddr_i >= start_addr_i[i*APB_ADDR_WIDTH +: APB_ADDR_WIDTH]) &&
             (paddr_i <= end_addr_i[i*APB_ADDR_WIDTH +: APB_ADDR_WIDTH])) begin
            hit     = 1'b1;
            hit_idx = IDX_W'(i);
         end
      end
   end

   // Response of the currently selected downstream port.
   always_comb begin
      sel_ready = m_pready_i[idx_q];
      sel_err   = m_pslverr_i[idx_q];
      sel_rdata = m_prdata_i[int'(idx_q)*APB_DATA_WIDTH +: APB_DATA_WIDTH];
   end

   assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

   // Outputs are registered: each is loaded on the transition into the state
   // in which it must be visible, and cleared on the transition out.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= ST_IDLE;
         idx_q       <= '0;
         miss_q      <= 1'b0;
         cnt_q       <= '0;
         m_psel_o    <= '0;
         m_penable_o <= 1'b0;
         m_paddr_o   <= '0;
         m_pwrite_o  <= 1'b0;
         m_pwdata_o  <= '0;
         prdata_o    <= '0;
         pready_o    <= 1'b0;
         pslverr_o   <= 1'b0;
`ifdef APB_NODE_ERR_LOG_EN
         resp_cause_q <= 2'b00;
`endif
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (psel_i && !penable_i) begin
                  m_paddr_o  <= paddr_i;
                  m_pwrite_o <= pwrite_i;
                  m_pwdata_o <= pwdata_i;
                  idx_q      <= hit_idx;
                  miss_q     <= !hit;
                  if (hit) begin
                     m_psel_o <= NB_MASTER'(1) << hit_idx;
                  end
                  state_q <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               if (miss_q) begin
                  state_q <= ST_ERR;
               end else begin
                  m_penable_o <= 1'b1;
                  cnt_q       <= '0;
                  state_q     <= ST_ACCESS;
               end
            end
            ST_ACCESS: begin
               if (sel_ready || timeout_hit) begin
                  m_psel_o    <= '0;
                  m_penable_o <= 1'b0;
                  cnt_q       <= '0;
                  pready_o    <= 1'b1;
                  prdata_o    <= sel_ready ? sel_rdata : ERR_DATA;
                  pslverr_o   <= sel_ready ? sel_err : 1'b1;
`ifdef APB_NODE_ERR_LOG_EN
                  resp_cause_q <= sel_ready ? (sel_err ? 2'b11 : 2'b00) : 2'b10;
`endif
                  state_q     <= ST_RESP;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            ST_ERR: begin
               pready_o  <= 1'b1;
               prdata_o  <= ERR_DATA;
               pslverr_o <= 1'b1;
`ifdef APB_NODE_ERR_LOG_EN
               resp_cause_q <= 2'b01;
`endif
               state_q   <= ST_RESP;
            end
            ST_RESP: begin
               pready_o  <= 1'b0;
               prdata_o  <= '0;
               pslverr_o <= 1'b0;
               state_q   <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

`ifdef APB_NODE_ERR_LOG_EN
   logic err_evt;
   assign err_evt = (state_q == ST_RESP) && pslverr_o;

   // Sticky log; a clear coinciding with a new error lets the new error in.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         err_valid_o <= 1'b0;
         err_addr_o  <= '0;
         err_cause_o <= 2'b00;
      end else if (err_evt && (!err_valid_o || err_clr_i)) begin
         err_valid_o <= 1'b1;
         err_addr_o  <= m_paddr_o;
         err_cause_o <= resp_cause_q;
      end else if (err_clr_i) begin
         err_valid_o <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_apb_periph_node.sv
module tb_apb_periph_node;

   localparam int unsigned NBM = 4;
   localparam int unsigned AW  = 32;
   localparam int unsigned DW  = 32;
   localparam logic [31:0] ERRD = 32'hBADACCE5;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               psel, penable, pwrite;
   logic [AW-1:0]      paddr;
   logic [DW-1:0]      pwdata;
   logic [DW-1:0]      prdata;
   logic               pready, pslverr;
   logic [NBM*AW-1:0]  start_addr, end_addr;
   logic [NBM-1:0]     m_psel;
   logic               m_penable, m_pwrite;
   logic [AW-1:0]      m_paddr;
   logic [DW-1:0]      m_pwdata;
   logic [NBM*DW-1:0]  m_prdata;
   logic [NBM-1:0]     m_pready, m_pslverr;
`ifdef APB_NODE_ERR_LOG_EN
   logic               err_clr;
   logic               err_valid;
   logic [AW-1:0]      err_addr;
   logic [1:0]         err_cause;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   apb_periph_node #(
      .NB_MASTER(NBM),
      .APB_ADDR_WIDTH(AW),
      .APB_DATA_WIDTH(DW),
      .TIMEOUT_CYCLES(8),
      .ERR_RDATA(ERRD)
   ) dut (
      .clk_i(clk),
      .rst_ni(rst_n),
      .psel_i(psel),
      .penable_i(penable),
      .paddr_i(paddr),
      .pwrite_i(pwrite),
      .pwdata_i(pwdata),
      .prdata_o(prdata),
      .pready_o(pready),
      .pslverr_o(pslverr),
      .start_addr_i(start_addr),
      .end_addr_i(end_addr),
      .m_psel_o(m_psel),
      .m_penable_o(m_penable),
      .m_paddr_o(m_paddr),
      .m_pwrite_o(m_pwrite),
      .m_pwdata_o(m_pwdata),
      .m_prdata_i(m_prdata),
      .m_pready_i(m_pready),
      .m_pslverr_i(m_pslverr)
`ifdef APB_NODE_ERR_LOG_EN
      ,
      .err_clr_i(err_clr),
      .err_valid_o(err_valid),
      .err_addr_o(err_addr),
      .err_cause_o(err_cause)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present the setup phase, cross the edge that samples it, then raise penable.
   task automatic xfer_start(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d);
      psel    = 1'b1;
      penable = 1'b0;
      paddr   = a;
      pwrite  = w;
      pwdata  = d;
      step();
      penable = 1'b1;
   endtask

   task automatic bus_idle();
      psel    = 1'b0;
      penable = 1'b0;
   endtask

   initial begin
      rst_n    = 1'b0;
      psel     = 1'b0;
      penable  = 1'b0;
      pwrite   = 1'b0;
      paddr    = '0;
      pwdata   = '0;
      m_pready = 4'b1111;
      m_pslverr = 4'b0000;
      m_prdata = {32'h0000_0033, 32'h0000_0022, 32'h0000_0011, 32'h0000_0055};
      // port2 and port3 overlap on 0x1A10_2800..0x1A10_2FFF
      start_addr = {32'h1A10_2800, 32'h1A10_2000, 32'h1A10_1000, 32'h1A10_0000};
      end_addr   = {32'h1A10_3FFF, 32'h1A10_2FFF, 32'h1A10_1FFF, 32'h1A10_0FFF};
`ifdef APB_NODE_ERR_LOG_EN
      err_clr = 1'b0;
`endif

      repeat (3) step();
      check("rst_pready", {31'b0, pready}, 32'h0);
      check("rst_pslverr", {31'b0, pslverr}, 32'h0);
      check("rst_prdata", prdata, 32'h0);
      check("rst_m_psel", {28'b0, m_psel}, 32'h0);
      check("rst_m_paddr", m_paddr, 32'h0);
      rst_n = 1'b1;
      step();

      // 1: zero-wait read of port0
      xfer_start(32'h1A10_0000, 1'b0, 32'h0);
      check("rd0_setup_psel", {28'b0, m_psel}, 32'h1);
      check("rd0_setup_penable", {31'b0, m_penable}, 32'h0);
      check("rd0_setup_paddr", m_paddr, 32'h1A10_0000);
      step();
      check("rd0_access_psel", {28'b0, m_psel}, 32'h1);
      check("rd0_access_penable", {31'b0, m_penable}, 32'h1);
      check("rd0_access_pready", {31'b0, pready}, 32'h0);
      step();
      check("rd0_pready", {31'b0, pready}, 32'h1);
      check("rd0_prdata", prdata, 32'h0000_0055);
      check("rd0_pslverr", {31'b0, pslverr}, 32'h0);
      check("rd0_psel_drop", {28'b0, m_psel}, 32'h0);
      bus_idle();
      step();
      check("rd0_pready_one_cycle", {31'b0, pready}, 32'h0);
      check("rd0_prdata_cleared", prdata, 32'h0);

      // 2: write to port1 with 4 wait states
      m_pready[1] = 1'b0;
      xfer_start(32'h1A10_1004, 1'b1, 32'hCAFE_0001);
      check("wr1_setup_psel", {28'b0, m_psel}, 32'h2);
      for (int k = 0; k < 5; k++) begin
         step();
         check("wr1_wait_pready", {31'b0, pready}, 32'h0);
         check("wr1_wait_psel", {28'b0, m_psel}, 32'h2);
         check("wr1_wait_pwrite", {31'b0, m_pwrite}, 32'h1);
         check("wr1_wait_pwdata", m_pwdata, 32'hCAFE_0001);
      end
      m_pready[1] = 1'b1;
      step();
      check("wr1_pready", {31'b0, pready}, 32'h1);
      check("wr1_pslverr", {31'b0, pslverr}, 32'h0);
      bus_idle();
      step();

      // 3: decode miss
      xfer_start(32'h1A20_0000, 1'b0, 32'h0);
      check("miss_setup_psel", {28'b0, m_psel}, 32'h0);
      step();
      check("miss_err_psel", {28'b0, m_psel}, 32'h0);
      check("miss_err_pready", {31'b0, pready}, 32'h0);
      step();
      check("miss_pready", {31'b0, pready}, 32'h1);
      check("miss_prdata", prdata, ERRD);
      check("miss_pslverr", {31'b0, pslverr}, 32'h1);
      bus_idle();
      step();
`ifdef APB_NODE_ERR_LOG_EN
      check("log_miss_valid", {31'b0, err_valid}, 32'h1);
      check("log_miss_addr", err_addr, 32'h1A20_0000);
      check("log_miss_cause", {30'b0, err_cause}, 32'h1);
`endif

      // 4: timeout on port3 (0x1A10_3000 is outside port2's window)
      m_pready[3] = 1'b0;
      xfer_start(32'h1A10_3000, 1'b0, 32'h0);
      check("to_setup_psel", {28'b0, m_psel}, 32'h8);
      for (int k = 0; k < 8; k++) begin
         step();
         check("to_access_psel", {28'b0, m_psel}, 32'h8);
         check("to_access_pready", {31'b0, pready}, 32'h0);
      end
      step();
      check("to_pready", {31'b0, pready}, 32'h1);
      check("to_pslverr", {31'b0, pslverr}, 32'h1);
      check("to_prdata", prdata, ERRD);
      check("to_psel_drop", {28'b0, m_psel}, 32'h0);
      bus_idle();
      m_pready[3] = 1'b1;
      step();
`ifdef APB_NODE_ERR_LOG_EN
      check("log_sticky_cause", {30'b0, err_cause}, 32'h1);
      check("log_sticky_addr", err_addr, 32'h1A20_0000);
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      check("log_cleared", {31'b0, err_valid}, 32'h0);
`endif

      // 5: back-to-back, port0 then overlap address resolving to port2 (error)
      m_pslverr[2] = 1'b1;
      xfer_start(32'h1A10_0010, 1'b0, 32'h0);
      step();
      step();
      check("b2b_a_pready", {31'b0, pready}, 32'h1);
      check("b2b_a_prdata", prdata, 32'h0000_0055);
      check("b2b_a_pslverr", {31'b0, pslverr}, 32'h0);
      step();
      xfer_start(32'h1A10_2800, 1'b0, 32'h0);
      check("b2b_b_setup_psel", {28'b0, m_psel}, 32'h4);
      step();
      check("b2b_b_access_pready", {31'b0, pready}, 32'h0);
      step();
      check("b2b_b_pready", {31'b0, pready}, 32'h1);
      check("b2b_b_prdata", prdata, 32'h0000_0022);
      check("b2b_b_pslverr", {31'b0, pslverr}, 32'h1);
      bus_idle();
      m_pslverr[2] = 1'b0;
      step();
`ifdef APB_NODE_ERR_LOG_EN
      check("log_slverr_valid", {31'b0, err_valid}, 32'h1);
      check("log_slverr_cause", {30'b0, err_cause}, 32'h3);
      check("log_slverr_addr", err_addr, 32'h1A10_2800);
`endif

      // 6: reset during ACCESS, then a fresh read at the top of port0
      m_pready[1] = 1'b0;
      xfer_start(32'h1A10_1000, 1'b1, 32'h1234_5678);
      check("rst_setup_psel", {28'b0, m_psel}, 32'h2);
      step();
      check("rst_access_penable", {31'b0, m_penable}, 32'h1);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_mid_psel", {28'b0, m_psel}, 32'h0);
      check("rst_mid_penable", {31'b0, m_penable}, 32'h0);
      check("rst_mid_paddr", m_paddr, 32'h0);
      check("rst_mid_pwrite", {31'b0, m_pwrite}, 32'h0);
      check("rst_mid_pwdata", m_pwdata, 32'h0);
      bus_idle();
      m_pready[1] = 1'b1;
      step();
      rst_n = 1'b1;
      step();
      xfer_start(32'h1A10_0FFF, 1'b0, 32'h0);
      check("post_rst_setup_psel", {28'b0, m_psel}, 32'h1);
      step();
      step();
      check("post_rst_pready", {31'b0, pready}, 32'h1);
      check("post_rst_prdata", prdata, 32'h0000_0055);
      check("post_rst_pslverr", {31'b0, pslverr}, 32'h0);
      bus_idle();
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/apb_periph_node.md
Name: apb_periph_node

Overview:
- Parametrised APB 1-to-N peripheral interconnect node; successor to the fixed-map peripheral bus wrapper.
- Decodes one upstream APB transfer onto NB_MASTER downstream peripheral ports using runtime start/end address vectors.
- Adds behaviour the previous node lacks: registered decode, decode-miss error response, per-transfer slave timeout with forced PSLVERR.
- Sits between the AXI-to-APB bridge and the SoC peripherals (UART, GPIO, SPI, timer, event unit, I2C, FLL, SoC ctrl, debug, accelerators).

Parameters:
- NB_MASTER, 10, number of downstream peripheral ports (1..32)
- APB_ADDR_WIDTH, 32, address width
- APB_DATA_WIDTH, 32, data width
- TIMEOUT_CYCLES, 256, maximum ACCESS cycles before forced error; 0 disables the timeout
- ERR_RDATA, 32'hBADACCE5, PRDATA returned on a decode miss or timeout (truncated or zero-extended to APB_DATA_WIDTH)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- psel_i  in  1  upstream select
- penable_i  in  1  upstream enable
- paddr_i  in  APB_ADDR_WIDTH  upstream address
- pwrite_i  in  1  upstream write
- pwdata_i  in  APB_DATA_WIDTH  upstream write data
- prdata_o  out  APB_DATA_WIDTH  upstream read data
- pready_o  out  1  upstream ready
- pslverr_o  out  1  upstream error
- start_addr_i  in  NB_MASTER*APB_ADDR_WIDTH  inclusive region start per port
- end_addr_i  in  NB_MASTER*APB_ADDR_WIDTH  inclusive region end per port
- m_psel_o  out  NB_MASTER  downstream one-hot select
- m_penable_o  out  1  downstream enable (shared)
- m_paddr_o  out  APB_ADDR_WIDTH  downstream address (broadcast, registered)
- m_pwrite_o  out  1  downstream write (broadcast, registered)
- m_pwdata_o  out  APB_DATA_WIDTH  downstream write data (broadcast, registered)
- m_prdata_i  in  NB_MASTER*APB_DATA_WIDTH  downstream read data
- m_pready_i  in  NB_MASTER  downstream ready
- m_pslverr_i  in  NB_MASTER  downstream error

Behaviour:
- Reset (async, rst_ni=0): FSM to IDLE; all outputs 0; timeout counter 0; address, write and data registers 0.
- Decode rule: port i hits when start_i <= addr <= end_i (unsigned). On overlap the lowest index wins. No hit means a miss.
- FSM states: IDLE, SETUP, ACCESS, ERR, RESP.
- IDLE: on psel_i=1 and penable_i=0, latch paddr_i, pwrite_i and pwdata_i, register the hit index and the miss flag, then go to SETUP. Otherwise stay.
- SETUP, hit: m_psel_o[idx]=1, m_penable_o=0, then ACCESS.
- SETUP, miss: no m_psel_o asserted, then ERR.
- ACCESS: m_psel_o[idx]=1, m_penable_o=1, counter increments each cycle.
  - If m_pready_i[idx]=1: capture m_prdata_i[idx] and m_pslverr_i[idx], clear counter, then RESP.
  - Else if TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1: capture ERR_RDATA with slverr=1, clear counter, then RESP.
  - Downstream select drops in the cycle after the exit.
- ERR: capture ERR_RDATA with slverr=1, then RESP.
- RESP: pready_o=1 for exactly one cycle with the captured prdata_o and pslverr_o, then IDLE. In all other states pready_o=0, pslverr_o=0 and prdata_o=0.
- Latency: against a zero-wait slave, pready_o asserts 3 cycles after the upstream setup cycle. Decode miss also gives 3 cycles. Timeout gives TIMEOUT_CYCLES+2 cycles.
- Back-to-back: a setup presented in the cycle after RESP is accepted in IDLE; no transfer is lost.
- Upstream psel_i deasserting mid-transfer (protocol violation) is ignored; the transfer completes.
- Address and data inputs are sampled only in IDLE. start_addr_i and end_addr_i must be stable during a transfer.
- Reset asserted mid-transfer: immediate return to IDLE and all outputs 0. The downstream peripheral sees psel drop.

Optional Feature:
- Macro APB_NODE_ERR_LOG_EN.
- Defined: adds ports err_clr_i (in, 1), err_valid_o (out, 1), err_addr_o (out, APB_ADDR_WIDTH) and err_cause_o (out, 2: 01 miss, 10 timeout, 11 slave PSLVERR).
  - On the first error RESP while err_valid_o=0: latch the address and cause, and set err_valid_o. The log is sticky; later errors do not overwrite it.
  - err_clr_i=1 clears err_valid_o next cycle. If the clear and a new error land in the same cycle, the new error wins.
  - All logging fields reset to 0.
- Undefined: none of these ports or registers exist.

Test Plan:
- Read 0x1A10_0000, UART port0 region 0x1A10_0000–0x1A10_0FFF, zero-wait, m_prdata=0x55 -> m_psel_o=0x001 for 2 cycles; pready_o=1 at setup+3; prdata_o=0x55; pslverr_o=0.
- Write 0x1A10_1004, data 0xCAFE0001, GPIO port1 inserts 4 wait states -> m_pwdata_o=0xCAFE0001 and m_pwrite_o=1 throughout; pready_o at setup+7; pslverr_o=0.
- Read of unmapped 0x1A20_0000 -> no m_psel_o bit set; pready_o at setup+3; prdata_o=ERR_RDATA; pslverr_o=1.
- TIMEOUT_CYCLES=8, port3 never ready -> m_psel_o[3] drops after 8 ACCESS cycles; pready_o=1 with pslverr_o=1.
- Two back-to-back transfers to ports 0 and 2, with port2 returning m_pslverr_i=1 -> first OK, second pslverr_o=1; no IDLE cycles wasted.
- Assert rst_ni=0 during ACCESS, then release and issue a new read -> all outputs 0 immediately; the next transfer completes normally. With APB_NODE_ERR_LOG_EN, a miss logs addr and cause=01; err_clr_i clears err_valid_o.
